// File: rtl/tracker_pkg.sv
// Shared types and constants for the multi-drive head-position tracker:
// step FSM state encoding, default parameter values and the width helper.
package tracker_pkg;

    localparam int DEF_NUM_DRIVES    = 2;
    localparam int DEF_NUM_TRACKS    = 77;
    localparam int DEF_LOWER_THRESH  = 43;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILTER,
        ST_UPDATE,
        ST_WAIT_LOW
    } step_state_t;

    // Bit width needed to index n items; never less than one bit.
    function automatic int clog2_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_drive_tracker_if.sv
// Drive-side bus of the tracker: asynchronous step/dir/select/track-00
// inputs and the registered track position outputs.
interface multi_drive_tracker_if
    import tracker_pkg::*;
#(
    parameter int DRV_W = clog2_w(DEF_NUM_DRIVES),
    parameter int TRK_W = clog2_w(DEF_NUM_TRACKS)
);
    logic             step;
    logic             dir;
    logic [DRV_W-1:0] drivenum;
    logic             zero_track;
    logic             lower_track;
    logic [TRK_W-1:0] track;
    logic             step_err;

    modport master (
        output step, dir, drivenum, zero_track,
        input  lower_track, track, step_err
    );

    modport slave (
        input  step, dir, drivenum, zero_track,
        output lower_track, track, step_err
    );
endinterface

// File: rtl/tracker_sync.sv
// Multi-flop synchroniser for a bundle of asynchronous inputs.
// Every bit sees the same depth so a bundle stays mutually consistent.
module tracker_sync
    import tracker_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] pipe;

    // Shift the raw inputs through STAGES flops; stage 0 samples the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];
endmodule

// File: rtl/multi_drive_tracker.sv
// Tracks the head position of NUM_DRIVES drives from an asynchronous
// step/dir interface. One step FSM serves all drives; the drive and
// direction are latched at the start of each step.
// Optional: TRACKER_STEP_FILTER_EN adds a glitch filter requiring
// FILTER_CYCLES consecutive synchronised-high cycles before a step counts.
module multi_drive_tracker
    import tracker_pkg::*;
#(
    parameter int NUM_DRIVES   = DEF_NUM_DRIVES,
    parameter int NUM_TRACKS   = DEF_NUM_TRACKS,
    parameter int LOWER_THRESH = DEF_LOWER_THRESH,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
`ifdef TRACKER_STEP_FILTER_EN
    ,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
`endif
) (
    input logic                  clk,
    input logic                  rst,
    multi_drive_tracker_if.slave bus
);
    localparam int DRV_W = clog2_w(NUM_DRIVES);
    localparam int TRK_W = clog2_w(NUM_TRACKS);
    localparam int SW    = DRV_W + 3;

    logic [SW-1:0]    async_in, sync_out;
    logic             s_step, s_dir, s_zero;
    logic [DRV_W-1:0] s_drv;

    assign async_in = {bus.step, bus.dir, bus.zero_track, bus.drivenum};

    tracker_sync #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (async_in),
        .q   (sync_out)
    );

    assign {s_step, s_dir, s_zero, s_drv} = sync_out;

    step_state_t      state, state_nxt;
    logic             cap_dir;
    logic [DRV_W-1:0] cap_drv;
    logic             qualified;

`ifdef TRACKER_STEP_FILTER_EN
    localparam int FC_W = clog2_w(FILTER_CYCLES);
    logic [FC_W-1:0] filt_cnt;

    // Count consecutive high cycles spent in FILTER; cleared outside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        filt_cnt <= '0;
        else if (state != ST_FILTER)    filt_cnt <= '0;
        else if (s_step && !qualified)  filt_cnt <= filt_cnt + 1'b1;
    end

    assign qualified = (filt_cnt == FC_W'(FILTER_CYCLES - 1));
`else
    assign qualified = 1'b1;
`endif

    // Step FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: one count per high phase; WAIT_LOW blocks a held step.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (s_step) state_nxt = ST_FILTER;
            ST_FILTER:   if (!s_step)        state_nxt = ST_IDLE;
                         else if (qualified) state_nxt = ST_UPDATE;
            ST_UPDATE:   state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!s_step) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Latch drive and direction as the step is first seen, so later
    // changes on those pins cannot redirect an in-flight step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_dir <= 1'b0;
            cap_drv <= '0;
        end else if (state == ST_IDLE && s_step) begin
            cap_dir <= s_dir;
            cap_drv <= s_drv;
        end
    end

    logic [NUM_DRIVES-1:0][TRK_W-1:0] cnt;
    logic [TRK_W-1:0]                 sel_cnt, cap_cnt;
    logic                             do_update, at_limit, zero_on_cap;

    // Pick the counters for the displayed drive and the stepping drive;
    // out-of-range selects read as zero.
    always_comb begin
        sel_cnt = '0;
        cap_cnt = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (s_drv == DRV_W'(i))   sel_cnt = cnt[i];
            if (cap_drv == DRV_W'(i)) cap_cnt = cnt[i];
        end
    end

    assign do_update   = (state == ST_UPDATE);
    assign at_limit    = cap_dir ? (cap_cnt == TRK_W'(NUM_TRACKS - 1))
                                 : (cap_cnt == '0);
    assign zero_on_cap = s_zero && (s_drv == cap_drv);

    for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_drv
        logic [TRK_W-1:0] pos;
        logic             zero_hit, upd_hit;

        assign zero_hit = s_zero && (s_drv == DRV_W'(i));
        assign upd_hit  = do_update && (cap_drv == DRV_W'(i));

        // Per-drive position: track-00 clear wins over a step; steps
        // saturate at both ends of the travel.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                       pos <= '0;
            else if (zero_hit)             pos <= '0;
            else if (upd_hit && !at_limit) pos <= cap_dir ? pos + 1'b1 : pos - 1'b1;
        end

        assign cnt[i] = pos;
    end

    logic [TRK_W-1:0] track_q;
    logic             lower_q, err_q;

    // Register the selected drive's position, its write-current flag and
    // the rejected-step pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            track_q <= '0;
            lower_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            track_q <= sel_cnt;
            lower_q <= int'(sel_cnt) > LOWER_THRESH;
            err_q   <= do_update && at_limit && !zero_on_cap;
        end
    end

    assign bus.track       = track_q;
    assign bus.lower_track = lower_q;
    assign bus.step_err    = err_q;
endmodule

// File: doc/multi_drive_tracker.md
MULTI_DRIVE_TRACKER -- requirements
Module: multi_drive_tracker

Interface
REQ-001 Parameter NUM_DRIVES, default 2, number of drives tracked independently (1..8).
REQ-002 Parameter NUM_TRACKS, default 77, tracks per drive; valid track range 0..NUM_TRACKS-1.
REQ-003 Parameter LOWER_THRESH, default 43; lower_track asserts when the selected drive's track is greater than this value.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth for all asynchronous inputs (>=2).
REQ-005 Ports: clk input 1, the single system clock; rising edge only.
REQ-006 Ports: rst input 1, reset, asynchronous, active-high.
REQ-007 Ports: step input 1, async head-step strobe, idle 0.
REQ-008 Ports: dir input 1, async direction; 1 = step in (track+1), 0 = step out (track-1).
REQ-009 Ports: drivenum input DRV_W = max(1,clog2(NUM_DRIVES)), async drive select.
REQ-010 Ports: zero_track input 1, async track-00 sensor of the selected drive, active-high.
REQ-011 Ports: lower_track output 1, registered reduced-write-current flag for the selected drive.
REQ-012 Ports: track output TRK_W = clog2(NUM_TRACKS), registered track of the selected drive.
REQ-013 Ports: step_err output 1, one-cycle pulse on a step rejected at a range limit.

Function
REQ-014 step, dir, drivenum and zero_track SHALL each pass through SYNC_STAGES flops before any use.
REQ-015 Step FSM states: IDLE, FILTER, UPDATE, WAIT_LOW; IDLE->FILTER on synchronised step=1; FILTER->UPDATE when the qualification of REQ-025/026 is met; UPDATE->WAIT_LOW unconditionally; WAIT_LOW->IDLE on synchronised step=0; FILTER->IDLE if step drops before qualification.
REQ-016 dir and drivenum SHALL be captured on the IDLE->FILTER transition; later changes SHALL NOT affect that step.
REQ-017 In UPDATE the captured drive's counter SHALL increment (dir=1) or decrement (dir=0) by exactly one.
REQ-018 Increment at NUM_TRACKS-1 or decrement at 0 SHALL leave the counter unchanged and pulse step_err for one cycle.
REQ-019 Synchronised zero_track=1 SHALL clear the counter of the currently synchronised drivenum every cycle it is high, with priority over a same-cycle UPDATE to that drive; the step is consumed and step_err stays 0.
REQ-020 Counters of non-addressed drives SHALL never change.
REQ-021 track and lower_track SHALL be registered from the synchronised drivenum's counter, valid one cycle after a counter or drivenum change.
REQ-022 A step held high continuously SHALL count once; only a return to 0 re-arms the FSM.

Reset
REQ-023 While rst=1: all counters 0, FSM IDLE, synchroniser flops 0, track=0, lower_track=0, step_err=0.
REQ-024 rst asserted mid-step SHALL abort it; after release a step still high is counted only once (held in WAIT_LOW until step low is seen? no: counted after rising-edge-equivalent qualification from IDLE).

Configuration
REQ-025 With TRACKER_STEP_FILTER_EN defined: FILTER SHALL require synchronised step=1 for FILTER_CYCLES (parameter, default 4) consecutive cycles; shorter pulses are discarded.
REQ-026 Without TRACKER_STEP_FILTER_EN: FILTER lasts exactly one cycle; filter counter logic is absent.

Structure
REQ-027 Package tracker_pkg SHALL hold the FSM state enum, default parameter constants and the clog2 width helper.
REQ-028 Sub-module tracker_sync (SYNC_STAGES-deep, parametrised width) SHALL implement REQ-014.

Verification
REQ-029 Reset, 10 MHz clk, filter off: 50 step pulses (dir=1, drive 0, 1 us high) -> track=50, lower_track=1 after step 44; drive 1 track stays 0.
REQ-030 Drive 0 at 76, one step dir=1 -> track stays 76, step_err one pulse; at 0, dir=0 step -> 0, step_err pulse.
REQ-031 Drive 1 at 20, zero_track=1 coincident with step -> track=0, step_err=0.
REQ-032 Filter on, FILTER_CYCLES=4: 200 ns step pulse -> no count; 1 us pulse -> +1.
REQ-033 drivenum toggles 0->1 during a step high -> only drive 0 counts; track follows drivenum within SYNC_STAGES+1 cycles.
REQ-034 rst pulsed mid-step with counters 30/10 -> all 0, lower_track=0; held step counted once after release.
